// File: rtl/alu_logic_issue_pkg.sv
// Shared ALU definitions: logic-unit opcodes, funct3 encodings and the issue
// buffer entry/state types.
package alu_logic_issue_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [1:0] logic_op_t;

    localparam logic_op_t LOGIC_AND = 2'b00;
    localparam logic_op_t LOGIC_OR  = 2'b01;
    localparam logic_op_t LOGIC_XOR = 2'b10;
    localparam logic_op_t LOGIC_BAD = 2'b11;

    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_XOR = 3'b100;

    typedef struct packed {
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic_op_t       opcode;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_logic_issue_decode.sv
// Combinational funct3 -> logic-unit opcode decode; anything that is not
// AND/OR/XOR is flagged illegal.
module logic_op_decode
    import alu_logic_issue_pkg::*;
#(
    parameter logic_op_t AND_OP = LOGIC_AND,
    parameter logic_op_t OR_OP  = LOGIC_OR,
    parameter logic_op_t XOR_OP = LOGIC_XOR,
    parameter logic_op_t BAD_OP = LOGIC_BAD
) (
    input  logic [2:0] funct3_i,
    output logic_op_t  opcode_o,
    output logic       illegal_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        opcode_o  = BAD_OP;
        illegal_o = 1'b1;
        case (funct3_i)
            F3_AND: begin opcode_o = AND_OP; illegal_o = 1'b0; end
            F3_OR:  begin opcode_o = OR_OP;  illegal_o = 1'b0; end
            F3_XOR: begin opcode_o = XOR_OP; illegal_o = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_logic_issue.sv
// Logic-unit issue stage: decodes funct3 on acceptance and holds requests in a
// 2-entry skid buffer with a registered in_ready_o.
module alu_logic_issue
    import alu_logic_issue_pkg::*;
#(
    parameter logic_op_t AND_OP = LOGIC_AND,
    parameter logic_op_t OR_OP  = LOGIC_OR,
    parameter logic_op_t XOR_OP = LOGIC_XOR,
    parameter logic_op_t BAD_OP = LOGIC_BAD
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] op_a_o,
    output logic [XLEN-1:0] op_b_o,
    output logic_op_t       opcode_o,
    output logic            illegal_o,
    output logic [15:0]     issue_cnt_o
);

    localparam entry_t RESET_ENTRY = '{op_a: '0, op_b: '0, opcode: AND_OP, illegal: 1'b0};

    buf_state_e  state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      skid_q, skid_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] cnt_q, cnt_d;

    logic_op_t   dec_opcode;
    logic        dec_illegal;
    entry_t      new_entry;
    logic        in_xfer;
    logic        out_xfer;

    logic_op_decode #(
        .AND_OP (AND_OP),
        .OR_OP  (OR_OP),
        .XOR_OP (XOR_OP),
        .BAD_OP (BAD_OP)
    ) u_decode (
        .funct3_i  (funct3_i),
        .opcode_o  (dec_opcode),
        .illegal_o (dec_illegal)
    );

    assign new_entry = '{op_a: op_a_i, op_b: op_b_i, opcode: dec_opcode, illegal: dec_illegal};
    assign in_xfer   = in_valid_i & in_ready_q;
    assign out_xfer  = out_valid_q & out_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q + {15'd0, out_xfer};

        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) begin
                    head_d  = new_entry;
                    state_d = ONE;
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_d = new_entry;
                    end else if (in_xfer) begin
                        skid_d  = new_entry;
                        state_d = TWO;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (out_xfer) begin
                    // The skid entry is always the younger one; promote it.
                    head_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end

        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= EMPTY;
            // NOTE: both payload slots are reset so the presented operands are
            // defined out of reset; they are only two entries wide.
            head_q      <= RESET_ENTRY;
            skid_q      <= RESET_ENTRY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking only, so every flop samples pre-edge values.
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign op_a_o      = head_q.op_a;
    assign op_b_o      = head_q.op_b;
    assign opcode_o    = head_q.opcode;
    assign illegal_o   = head_q.illegal;
    assign issue_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_logic_issue.sv
// Directed-vector bench for alu_logic_issue with hand-computed expectations.
module tb_alu_logic_issue;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic [1:0]  opcode_o;
    logic        illegal_o;
    logic [15:0] issue_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_logic_issue dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .funct3_i    (funct3_i),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .op_a_o      (op_a_o),
        .op_b_o      (op_b_o),
        .opcode_o    (opcode_o),
        .illegal_o   (illegal_o),
        .issue_cnt_o (issue_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        in_valid_i = v;
        funct3_i   = f3;
        op_a_i     = a;
        op_b_i     = b;
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_in_ready"},  in_ready_o,  1);
        check({pfx, "_out_valid"}, out_valid_o, 0);
        check({pfx, "_op_a"},      op_a_o,      0);
        check({pfx, "_op_b"},      op_b_o,      0);
        check({pfx, "_opcode"},    opcode_o,    0);
        check({pfx, "_illegal"},   illegal_o,   0);
        check({pfx, "_cnt"},       issue_cnt_o, 0);
    endtask

    initial begin
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);

        // Reset state
        #12;
        check_reset_values("rst");
        step();
        rst_n_i = 1'b1;

        // OR request, single-cycle latency, count one cycle after presentation
        out_ready_i = 1'b1;
        drive(1'b1, 3'b110, 32'hF0F0_0000, 32'h0000_0F0F);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("or_valid",   out_valid_o, 1);
        check("or_opcode",  opcode_o,    2'b01);
        check("or_illegal", illegal_o,   0);
        check("or_op_a",    op_a_o,      32'hF0F0_0000);
        check("or_op_b",    op_b_o,      32'h0000_0F0F);
        check("or_cnt0",    issue_cnt_o, 0);
        step();
        check("or_cnt1",    issue_cnt_o, 1);
        check("or_drained", out_valid_o, 0);

        // Back-pressure: three requests, third held upstream, then drain in order
        out_ready_i = 1'b0;
        drive(1'b1, 3'b111, 32'hAAAA_0001, 32'h1);
        step();
        check("bp_rdy_after1", in_ready_o, 1);
        check("bp_head_a1",    op_a_o,     32'hAAAA_0001);
        drive(1'b1, 3'b100, 32'hBBBB_0002, 32'h2);
        step();
        check("bp_rdy_after2", in_ready_o, 0);
        check("bp_hold_a2",    op_a_o,     32'hAAAA_0001);
        drive(1'b1, 3'b110, 32'hCCCC_0003, 32'h3);
        step();
        check("bp_rdy_held",   in_ready_o, 0);
        check("bp_hold_a3",    op_a_o,     32'hAAAA_0001);
        check("bp_hold_op",    opcode_o,   2'b00);
        check("bp_hold_cnt",   issue_cnt_o, 1);
        out_ready_i = 1'b1;
        step();
        check("bp_head_b",     op_a_o,     32'hBBBB_0002);
        check("bp_op_b",       opcode_o,   2'b10);
        check("bp_rdy_back",   in_ready_o, 1);
        check("bp_cnt2",       issue_cnt_o, 2);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("bp_head_c",     op_a_o,     32'hCCCC_0003);
        check("bp_op_c",       opcode_o,   2'b01);
        check("bp_cnt3",       issue_cnt_o, 3);
        step();
        check("bp_empty",      out_valid_o, 0);
        check("bp_cnt4",       issue_cnt_o, 4);

        // Unsupported funct3 still issues and counts
        drive(1'b1, 3'b001, 32'hDEAD_BEEF, 32'h5);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("bad_valid",   out_valid_o, 1);
        check("bad_opcode",  opcode_o,    2'b11);
        check("bad_illegal", illegal_o,   1);
        step();
        check("bad_cnt5",    issue_cnt_o, 5);

        // Flush while full, with a same-cycle incoming request
        out_ready_i = 1'b0;
        drive(1'b1, 3'b111, 32'h0000_00D0, 32'h0);
        step();
        drive(1'b1, 3'b111, 32'h0000_00E0, 32'h0);
        step();
        check("fl_full", in_ready_o, 0);
        flush_i = 1'b1;
        drive(1'b1, 3'b111, 32'h0000_00F0, 32'h0);
        step();
        flush_i = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("fl_valid", out_valid_o, 0);
        check("fl_ready", in_ready_o,  1);
        check("fl_cnt",   issue_cnt_o, 5);
        out_ready_i = 1'b1;
        drive(1'b1, 3'b100, 32'h0000_0123, 32'h0);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("fl_next_a", op_a_o, 32'h0000_0123);
        step();
        check("fl_next_cnt", issue_cnt_o, 6);

        // Asynchronous reset while full, away from any clock edge
        out_ready_i = 1'b0;
        drive(1'b1, 3'b110, 32'h0000_0A0A, 32'h0);
        step();
        drive(1'b1, 3'b100, 32'h0000_0B0B, 32'h0);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("ar_full", in_ready_o, 0);
        #3;
        rst_n_i = 1'b0;
        #1;
        check_reset_values("ar");
        step();
        rst_n_i     = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b1, 3'b111, 32'h0000_0C0C, 32'h0);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("ar_accept_valid", out_valid_o, 1);
        check("ar_accept_a",     op_a_o,      32'h0000_0C0C);
        step();
        check("ar_accept_cnt",   issue_cnt_o, 1);

        // Counter wrap: one accept edge, then one transfer per edge
        rst_n_i = 1'b0;
        step();
        rst_n_i     = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b1, 3'b110, 32'h1, 32'h2);
        repeat (65537) @(posedge clk_i);
        #1;
        check("wrap_zero", issue_cnt_o, 16'h0000);
        step();
        check("wrap_one",  issue_cnt_o, 16'h0001);
        drive(1'b0, 3'b000, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
